// File: rtl/cave_input_pkg.sv
// Shared types and scancode constants for the PS/2 key event path.
package cave_input_pkg;

  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } dec_state_t;

  localparam logic [7:0] SC_EXT         = 8'hE0;
  localparam logic [7:0] SC_BREAK       = 8'hF0;
  localparam logic [7:0] SC_PAUSE       = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  // Keyboard status/ack bytes that never describe a key.
  function automatic logic is_filler(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous key-event FIFO, combinational read of the head entry.
// Push is ignored when full and pop when empty; count/full/empty are registered-state views.
module key_event_fifo
  import cave_input_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         push_vld,
  input  key_event_t                   push_dat,
  input  logic                         pop_vld,
  output key_event_t                   pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  key_event_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push_vld & ~full;
  assign do_pop  = pop_vld & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 set-2 scancode bytes to toggle-style ps2_key events; byte to toggle is 2 cycles minimum.
// byte_ready drops while the event FIFO is full; events completing into a full FIFO are dropped.
module ps2_key_encoder
  import cave_input_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [10:0] ps2_key,
  output logic        overflow,
  output logic        busy
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP + 1);

  dec_state_t       state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             ev_vld_q, ev_vld_d;
  key_event_t       ev_dat_q, ev_dat_d;
  logic [GAP_W-1:0] gap_q;
  logic             byte_acc;
  logic             pop_vld;
  key_event_t       pop_dat;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  assign byte_ready = ~reset & (fifo_count != CNT_W'(FIFO_DEPTH));
  assign byte_acc   = byte_valid & byte_ready;
  assign busy       = (state_q != IDLE) | ~fifo_empty;
  // The gap counter's last cycle is also the next pop cycle, so toggles land exactly GAP apart.
  assign pop_vld    = ~fifo_empty & (gap_q <= GAP_W'(1));

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    to_d     = to_q;
    ev_vld_d = 1'b0;
    ev_dat_d = '{pressed: 1'b1, ext: 1'b0, code: byte_data};
    if (byte_acc) begin
      to_d = '0;
      case (state_q)
        IDLE: begin
          if (byte_data == SC_EXT) state_d = EXT;
          else if (byte_data == SC_BREAK) state_d = BRK;
          else if (byte_data == SC_PAUSE) begin
            state_d = SKIP;
            skip_d  = PAUSE_SKIP_LEN;
          end else if (!is_filler(byte_data)) ev_vld_d = 1'b1;
        end
        EXT: begin
          if (byte_data == SC_BREAK) state_d = EXT_BRK;
          else if (byte_data != SC_EXT) begin
            ev_vld_d     = 1'b1;
            ev_dat_d.ext = 1'b1;
            state_d      = IDLE;
          end
        end
        BRK: begin
          ev_vld_d         = 1'b1;
          ev_dat_d.pressed = 1'b0;
          state_d          = IDLE;
        end
        EXT_BRK: begin
          ev_vld_d         = 1'b1;
          ev_dat_d.pressed = 1'b0;
          ev_dat_d.ext     = 1'b1;
          state_d          = IDLE;
        end
        SKIP: begin
          if (skip_q <= 3'd1) begin
            state_d = IDLE;
            skip_d  = '0;
          end else skip_d = skip_q - 3'd1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_q == TO_W'(TIMEOUT - 1)) begin
        state_d = IDLE;
        skip_d  = '0;
        to_d    = '0;
      end else to_d = to_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      skip_q   <= '0;
      to_q     <= '0;
      ev_vld_q <= 1'b0;
      ev_dat_q <= '0;
      gap_q    <= '0;
      ps2_key  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      to_q     <= to_d;
      ev_vld_q <= ev_vld_d;
      ev_dat_q <= ev_dat_d;
      if (pop_vld) begin
        ps2_key <= {~ps2_key[10], pop_dat};
        gap_q   <= GAP_W'(GAP);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - GAP_W'(1);
      end
      if (ev_vld_q && fifo_full) overflow <= 1'b1;
    end
  end

  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .push_vld (ev_vld_q & ~fifo_full),
    .push_dat (ev_dat_q),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
